// File: rtl/sipo_shift_receiver_if.sv
// Serial line and parallel consumer signals of the SIPO receiver.
// The master side drives the serial line and ack; the slave side is the receiver.
interface sipo_shift_receiver_if #(
    parameter int unsigned WIDTH = 8
);
    localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    logic             ds;
    logic             ce_;
    logic             fr_;
    logic             ack;
    logic [WIDTH-1:0] q;
    logic             rdy;
    logic             ovr;
    logic             qs;
    logic             qs_;
    logic [CW-1:0]    cnt;

    modport master (
        output ds, ce_, fr_, ack,
        input  q, rdy, ovr, qs, qs_, cnt
    );

    modport slave (
        input  ds, ce_, fr_, ack,
        output q, rdy, ovr, qs, qs_, cnt
    );
endinterface

// File: rtl/sipo_shift_receiver.sv
// Serial-in / parallel-out receiver: shifts WIDTH bits into sr, latches the word into q
// and holds rdy until ack; overrun is flagged when an unacknowledged word is replaced.
module sipo_shift_receiver #(
    parameter int unsigned WIDTH     = 8,
    parameter bit          MSB_FIRST = 1'b1
) (
    input logic                  cp,
    input logic                  mr_,
    sipo_shift_receiver_if.slave bus
);
    localparam int unsigned CW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    logic [WIDTH-1:0] sr, sr_nxt;
    logic [WIDTH-1:0] sr_shift;
    logic [WIDTH-1:0] q_r, q_nxt;
    logic [CW-1:0]    cnt_r, cnt_nxt;
    logic             rdy_r, rdy_nxt;
    logic             ovr_r, ovr_nxt;
    logic             word_done;
    logic             cascade_bit;

    // Shift direction and the stage that leaves next are fixed by MSB_FIRST.
    generate
        if (MSB_FIRST) begin : g_msb
            assign sr_shift    = {sr[WIDTH-2:0], bus.ds};
            assign cascade_bit = sr[WIDTH-1];
        end else begin : g_lsb
            assign sr_shift    = {bus.ds, sr[WIDTH-1:1]};
            assign cascade_bit = sr[0];
        end
    endgenerate

    // State register; master reset overrides everything, including mid-word.
    always_ff @(posedge cp) begin
        if (!mr_) begin
            sr    <= '0;
            q_r   <= '0;
            cnt_r <= '0;
            rdy_r <= 1'b0;
            ovr_r <= 1'b0;
        end else begin
            sr    <= sr_nxt;
            q_r   <= q_nxt;
            cnt_r <= cnt_nxt;
            rdy_r <= rdy_nxt;
            ovr_r <= ovr_nxt;
        end
    end

    // Next state: frame sync beats shifting; the handshake runs regardless of ce_/fr_.
    always_comb begin
        sr_nxt    = sr;
        q_nxt     = q_r;
        cnt_nxt   = cnt_r;
        rdy_nxt   = rdy_r;
        ovr_nxt   = ovr_r;
        word_done = 1'b0;

        if (!bus.fr_) begin
            cnt_nxt = '0;
        end else if (!bus.ce_) begin
            sr_nxt = sr_shift;
            if (cnt_r == LAST) begin
                cnt_nxt   = '0;
                word_done = 1'b1;
            end else begin
                cnt_nxt = cnt_r + CW'(1);
            end
        end

        // A completing word acknowledged on the same edge retires the old one cleanly.
        if (word_done) begin
            q_nxt   = sr_shift;
            rdy_nxt = 1'b1;
            if (rdy_r) begin
                ovr_nxt = ~bus.ack;
            end
        end else if (rdy_r && bus.ack) begin
            rdy_nxt = 1'b0;
            ovr_nxt = 1'b0;
        end
    end

    assign bus.q   = q_r;
    assign bus.cnt = cnt_r;
    assign bus.rdy = rdy_r;
    assign bus.ovr = ovr_r;
    assign bus.qs  = cascade_bit;
    assign bus.qs_ = ~cascade_bit;
endmodule

// File: tb/tb_sipo_shift_receiver.sv
// Self-checking bench: three receivers (MSB-first, cascaded MSB-first, LSB-first)
// compared each edge against a bit-list reference model, plus directed word checks.
module tb_sipo_shift_receiver;
    logic cp;
    logic mr_;

    sipo_shift_receiver_if #(.WIDTH(8)) bus0 ();
    sipo_shift_receiver_if #(.WIDTH(8)) bus1 ();
    sipo_shift_receiver_if #(.WIDTH(8)) bus2 ();

    sipo_shift_receiver #(.WIDTH(8), .MSB_FIRST(1'b1)) u0 (.cp(cp), .mr_(mr_), .bus(bus0));
    sipo_shift_receiver #(.WIDTH(8), .MSB_FIRST(1'b1)) u1 (.cp(cp), .mr_(mr_), .bus(bus1));
    sipo_shift_receiver #(.WIDTH(8), .MSB_FIRST(1'b0)) u2 (.cp(cp), .mr_(mr_), .bus(bus2));

    // u1 is chained behind u0; control lines are shared.
    assign bus1.ds  = bus0.qs;
    assign bus1.ce_ = bus0.ce_;
    assign bus1.fr_ = bus0.fr_;
    assign bus1.ack = bus0.ack;
    assign bus2.ce_ = bus0.ce_;
    assign bus2.fr_ = bus0.fr_;
    assign bus2.ack = bus0.ack;

    initial cp = 1'b0;
    always #5 cp = ~cp;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference model: received bits of the current word and the last 8 bits shifted in.
    bit         m_hist [3][$];
    bit         m_word [3][$];
    logic [7:0] m_q    [3];
    bit         m_rdy  [3];
    bit         m_ovr  [3];
    bit         m_msb  [3];

    task automatic model_step(input int i, input bit d, input bit ce_n, input bit fr_n,
                              input bit ak, input bit mr_n);
        bit         done;
        logic [7:0] w;
        if (!mr_n) begin
            m_word[i].delete();
            m_hist[i].delete();
            for (int k = 0; k < 8; k++) m_hist[i].push_back(1'b0);
            m_q[i]   = 8'h00;
            m_rdy[i] = 1'b0;
            m_ovr[i] = 1'b0;
            return;
        end
        done = 1'b0;
        w    = 8'h00;
        if (!fr_n) begin
            m_word[i].delete();
        end else if (!ce_n) begin
            m_hist[i].push_back(d);
            void'(m_hist[i].pop_front());
            m_word[i].push_back(d);
            if (m_word[i].size() == 8) begin
                for (int k = 0; k < 8; k++)
                    if (m_word[i][k]) w = w | (m_msb[i] ? (8'h80 >> k) : (8'h01 << k));
                m_word[i].delete();
                done = 1'b1;
            end
        end
        if (done) begin
            if (m_rdy[i]) m_ovr[i] = !ak;
            m_q[i]   = w;
            m_rdy[i] = 1'b1;
        end else if (m_rdy[i] && ak) begin
            m_rdy[i] = 1'b0;
            m_ovr[i] = 1'b0;
        end
    endtask

    task automatic compare_inst(input int i, input logic [7:0] q, input logic rdy, input logic ovr,
                                input logic [2:0] cnt, input logic qs, input logic qsn);
        check($sformatf("u%0d.q", i),   32'(q),   32'(m_q[i]));
        check($sformatf("u%0d.rdy", i), 32'(rdy), 32'(m_rdy[i]));
        check($sformatf("u%0d.ovr", i), 32'(ovr), 32'(m_ovr[i]));
        check($sformatf("u%0d.cnt", i), 32'(cnt), 32'(m_word[i].size()));
        check($sformatf("u%0d.qs", i),  32'(qs),  32'(m_hist[i][0]));
        check($sformatf("u%0d.qs_", i), 32'(qsn), 32'(!m_hist[i][0]));
    endtask

    // One clock edge: drive inputs, advance the model, check all three receivers.
    task automatic tick(input bit d0, input bit d2, input bit ce_n, input bit fr_n,
                        input bit ak, input bit mr_n);
        bit d1;
        bus0.ds  = d0;
        bus2.ds  = d2;
        bus0.ce_ = ce_n;
        bus0.fr_ = fr_n;
        bus0.ack = ak;
        mr_      = mr_n;
        d1 = (m_hist[0].size() > 0) ? m_hist[0][0] : 1'b0;
        @(posedge cp);
        model_step(0, d0, ce_n, fr_n, ak, mr_n);
        model_step(1, d1, ce_n, fr_n, ak, mr_n);
        model_step(2, d2, ce_n, fr_n, ak, mr_n);
        #1;
        compare_inst(0, bus0.q, bus0.rdy, bus0.ovr, bus0.cnt, bus0.qs, bus0.qs_);
        compare_inst(1, bus1.q, bus1.rdy, bus1.ovr, bus1.cnt, bus1.qs, bus1.qs_);
        compare_inst(2, bus2.q, bus2.rdy, bus2.ovr, bus2.cnt, bus2.qs, bus2.qs_);
    endtask

    task automatic send_bit(input bit b, input bit ak);
        tick(b, b, 1'b0, 1'b1, ak, 1'b1);
    endtask

    task automatic send_byte(input logic [7:0] b, input bit ack_last);
        for (int k = 7; k >= 0; k--) send_bit(b[k], (k == 0) ? ack_last : 1'b0);
    endtask

    task automatic idle_ack();
        tick(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
    endtask

    task automatic do_reset();
        tick(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [7:0] src;
        logic [7:0] a5;
        m_msb[0] = 1'b1;
        m_msb[1] = 1'b1;
        m_msb[2] = 1'b0;
        bus0.ds = 1'b0; bus2.ds = 1'b0; bus0.ce_ = 1'b1; bus0.fr_ = 1'b1; bus0.ack = 1'b0; mr_ = 1'b0;

        do_reset();
        do_reset();
        check("rst.q", 32'(bus0.q), 32'h00);
        check("rst.qs_", 32'(bus0.qs_), 32'h1);

        // 0xA5 on 8 consecutive edges
        a5 = 8'hA5;
        for (int k = 7; k >= 0; k--) begin
            send_bit(a5[k], 1'b0);
            if (k > 0) begin
                check("a5.cnt", 32'(bus0.cnt), 32'(8 - k));
                check("a5.rdy_low", 32'(bus0.rdy), 32'h0);
            end
        end
        check("a5.q", 32'(bus0.q), 32'hA5);
        check("a5.rdy", 32'(bus0.rdy), 32'h1);
        check("a5.cnt0", 32'(bus0.cnt), 32'h0);
        check("a5.ovr", 32'(bus0.ovr), 32'h0);
        idle_ack();
        check("ack.rdy", 32'(bus0.rdy), 32'h0);

        // ce_ gap after bit 4
        for (int k = 7; k >= 4; k--) send_bit(a5[k], 1'b0);
        for (int g = 0; g < 3; g++) begin
            tick(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
            check("gap.cnt", 32'(bus0.cnt), 32'h4);
        end
        for (int k = 3; k >= 0; k--) send_bit(a5[k], 1'b0);
        check("gap.q", 32'(bus0.q), 32'hA5);
        check("gap.rdy", 32'(bus0.rdy), 32'h1);
        idle_ack();

        // overrun, then clear, then ack coinciding with completion
        send_byte(8'h3C, 1'b0);
        send_byte(8'hC3, 1'b0);
        check("ovr.q", 32'(bus0.q), 32'hC3);
        check("ovr.rdy", 32'(bus0.rdy), 32'h1);
        check("ovr.ovr", 32'(bus0.ovr), 32'h1);
        idle_ack();
        check("ovr.clr_rdy", 32'(bus0.rdy), 32'h0);
        check("ovr.clr_ovr", 32'(bus0.ovr), 32'h0);
        send_byte(8'h11, 1'b0);
        send_byte(8'h22, 1'b1);
        check("same.q", 32'(bus0.q), 32'h22);
        check("same.rdy", 32'(bus0.rdy), 32'h1);
        check("same.ovr", 32'(bus0.ovr), 32'h0);
        idle_ack();

        // frame resync after garbage bits
        send_bit(1'b1, 1'b0);
        send_bit(1'b1, 1'b0);
        send_bit(1'b0, 1'b0);
        tick(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        check("fr.cnt", 32'(bus0.cnt), 32'h0);
        for (int k = 7; k >= 1; k--) send_bit(k == 7, 1'b0);
        check("fr.rdy_early", 32'(bus0.rdy), 32'h0);
        send_bit(1'b1, 1'b0);
        check("fr.rdy", 32'(bus0.rdy), 32'h1);
        check("fr.q", 32'(bus0.q), 32'h81);

        // mid-word master reset
        send_bit(1'b1, 1'b0);
        send_bit(1'b1, 1'b0);
        send_bit(1'b1, 1'b0);
        do_reset();
        check("mr.q", 32'(bus0.q), 32'h00);
        check("mr.rdy", 32'(bus0.rdy), 32'h0);
        check("mr.cnt", 32'(bus0.cnt), 32'h0);
        check("mr.qs", 32'(bus0.qs), 32'h0);
        send_byte(8'h96, 1'b0);
        check("mr.clean_q", 32'(bus0.q), 32'h96);

        // cascade: parallel-to-serial source 0x5A then 0x00
        do_reset();
        src = 8'h5A;
        for (int k = 0; k < 8; k++) begin
            send_bit(src[7], 1'b0);
            src = src << 1;
        end
        send_byte(8'h00, 1'b0);
        check("casc.u0_q", 32'(bus0.q), 32'h00);
        check("casc.u1_q", 32'(bus1.q), 32'h5A);

        // bit order: 1 then seven 0s
        do_reset();
        send_byte(8'h80, 1'b0);
        check("lsb.u2_q", 32'(bus2.q), 32'h01);
        check("msb.u0_q", 32'(bus0.q), 32'h80);

        // randomized traffic
        for (int n = 0; n < 500; n++) begin
            tick(1'($urandom), 1'($urandom), ($urandom_range(9) < 3), ($urandom_range(19) != 0),
                 ($urandom_range(9) < 3), ($urandom_range(99) != 0));
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule

// File: doc/sipo_shift_receiver.md
Name: sipo_shift_receiver

Overview:
- 8-bit-class serial-in / parallel-out receiver: the receiving end of the parallel-to-serial shift-register link.
- Shifts one bit per enabled clock into an internal shift register and counts bits. After WIDTH bits it latches the word onto a holding register and raises a ready/acknowledge handshake.
- Provides a serial cascade output so stages can be chained, and a frame-sync input for bit-alignment recovery.
- Sits between the serial line and the parallel consumer logic.

Parameters:
WIDTH, 8, word length in bits; legal range 2..32.
MSB_FIRST, 1, 1 = first received bit lands in q[WIDTH-1]; 0 = first bit lands in q[0].

Ports:
cp  input  1  clock; all state changes on rising edge.
mr_  input  1  master reset, synchronous, active-low.
ds  input  1  serial data in, sampled on rising cp when ce_=0.
ce_  input  1  clock-enable, active-low; 1 = inhibit shifting (hold).
fr_  input  1  frame sync, synchronous, active-low; restarts bit count.
ack  input  1  consumer acknowledge of the latched word.
q  output  WIDTH  latched parallel word (holding register).
rdy  output  1  word available in q, held until acknowledged.
ovr  output  1  overrun: a word was overwritten before ack.
qs  output  1  serial cascade out: the register stage that leaves on the next shift.
qs_  output  1  complement of qs.
cnt  output  CW  bits received in the current word, CW = clog2(WIDTH).

Behaviour:
- All logic is synchronous to rising cp. mr_=0 has top priority on any edge, including mid-word. It forces: sr=0, q=0, cnt=0, rdy=0, ovr=0, qs=0, qs_=1.
- Priority order per edge: mr_ > fr_ > shift (ce_=0) > hold. ack processing is independent of ce_ and fr_.
- Shift, MSB_FIRST=1: sr <= {sr[WIDTH-2:0], ds}; qs = sr[WIDTH-1].
- Shift, MSB_FIRST=0: sr <= {ds, sr[WIDTH-1:1]}; qs = sr[0].
- qs/qs_ are derived directly from sr (no extra register), so a chained stage sees each bit exactly WIDTH shifts after it entered.
- Bit counter:
  - On a shift with cnt < WIDTH-1: cnt <= cnt+1.
  - On a shift with cnt = WIDTH-1: cnt <= 0, q <= the post-shift sr value (including the ds sampled this edge), rdy <= 1.
  - Latency: q and rdy are valid immediately after the edge that samples bit WIDTH. There is no extra pipeline stage.
- fr_=0:
  - cnt <= 0; the ds sampled that edge is discarded; sr is not shifted.
  - q, rdy and ovr are unchanged, and no partial word is latched.
  - The next enabled edge with fr_=1 samples bit 1 of the new word.
- ce_=1 with fr_=1: sr, cnt and q hold their values.
- Handshake:
  - rdy=1 and ack=1 at an edge, with no word completing: rdy <= 0, ovr <= 0.
  - Word completes at an edge with rdy=0: rdy <= 1, q updated, ovr unchanged.
  - Word completes with rdy=1 and ack=0: q overwritten, rdy stays 1, ovr <= 1 (sticky until ack or reset).
  - Word completes with rdy=1 and ack=1 on the same edge: the old word counts as consumed. The result is q = new word, rdy=1, ovr <= 0.
  - ack with rdy=0: no effect.
- Wrap-around: cnt never exceeds WIDTH-1. Back-to-back words with ce_ held low yield rdy every WIDTH cycles, with no dead cycle.
- No combinational path from inputs to outputs. qs/qs_ depend on sr only.

Test Plan:
- Reset then MSB_FIRST=1, WIDTH=8: shift 1,0,1,0,0,1,0,1 on 8 consecutive edges -> after edge 8: q=0xA5, rdy=1, cnt=0, ovr=0. At edges 1..7: rdy=0, cnt=1..7.
- ce_ gaps: same 0xA5 stream with ce_=1 for 3 cycles after bit 4 -> cnt holds at 4 during the gap; q=0xA5 after the 8th enabled edge; total 11 edges.
- Overrun: receive 0x3C without ack, then 0xC3 -> q=0xC3, rdy=1, ovr=1. Then ack for one cycle -> rdy=0, ovr=0. Also: ack on the same edge as completion -> q=new word, rdy=1, ovr=0.
- Frame resync: 3 garbage bits, fr_=0 for one edge, then 0x81 -> q=0x81, and rdy rises exactly 8 enabled edges after fr_ deasserts. A mid-word mr_=0 pulse -> all outputs at reset values, with the next 8 bits forming a clean word.
- Cascade/loopback: drive ds from an 8-bit parallel-to-serial source loaded with 0x5A (MSB first). Chain qs into a second instance, then shift 16 bits, 0x5A followed by 0x00 -> first instance q=0x00, second instance q=0x5A. qs_ is always the complement of qs.
- MSB_FIRST=0, WIDTH=8: shift 1,0,0,0,0,0,0,0 -> q=0x01 (MSB_FIRST=1 with the same stream gives q=0x80).
